// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: decodes scanner key events into hex digits, assembles an
// entry value with backspace/enter, and queues entered values in a FWFT FIFO.
//
// state         | meaning
// --------------|----------------------------------
// ENTRY_EMPTY   | no digits typed (digit_cnt = 0)
// ENTRY_PARTIAL | 1..7 digits typed
// ENTRY_FULL    | 8 digits typed, further digits overflow
module keypad_entry_buffer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    key_coord,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [31:0]                   entry_value,
  output logic [3:0]                    digit_cnt,
  output logic [31:0]                   rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ENTRY_EMPTY   = 2'd0,
    ENTRY_PARTIAL = 2'd1,
    ENTRY_FULL    = 2'd2
  } entry_state_t;

  entry_state_t state_q, state_d;
  logic [31:0]  entry_q, entry_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   err_q, err_set;

  logic [31:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;

  logic [2:0] row_dec, col_dec;
  logic       key_valid;
  logic [3:0] key_idx;
  logic       is_digit, is_bksp, is_enter;
  logic [3:0] dval;
  logic       push, pop_ok, full, empty;

  // Returns {valid, index-1} for an active-low one-hot nibble.
  function automatic logic [2:0] nib_dec(input logic [3:0] n);
    case (n)
      4'b0111: nib_dec = 3'b100;
      4'b1011: nib_dec = 3'b101;
      4'b1101: nib_dec = 3'b110;
      4'b1110: nib_dec = 3'b111;
      default: nib_dec = 3'b000;
    endcase
  endfunction

  assign row_dec   = nib_dec(key_coord[7:4]);
  assign col_dec   = nib_dec(key_coord[3:0]);
  assign key_valid = row_dec[2] & col_dec[2];
  assign key_idx   = {row_dec[1:0], col_dec[1:0]};

  always_comb begin
    is_digit = 1'b1;
    is_bksp  = 1'b0;
    is_enter = 1'b0;
    dval     = 4'h0;
    case (key_idx)
      4'd0:  dval = 4'h1;
      4'd1:  dval = 4'h2;
      4'd2:  dval = 4'h3;
      4'd3:  dval = 4'hA;
      4'd4:  dval = 4'h4;
      4'd5:  dval = 4'h5;
      4'd6:  dval = 4'h6;
      4'd7:  dval = 4'hB;
      4'd8:  dval = 4'h7;
      4'd9:  dval = 4'h8;
      4'd10: dval = 4'h9;
      4'd11: dval = 4'hC;
      4'd12: begin is_digit = 1'b0; is_bksp = 1'b1; end
      4'd13: dval = 4'h0;
      4'd14: begin is_digit = 1'b0; is_enter = 1'b1; end
      default: dval = 4'hD;
    endcase
  end

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign pop_ok = rd_en & ~empty;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    err_set = 2'b00;
    if (key_valid) begin
      if (is_digit) begin
        if (state_q == ENTRY_FULL) begin
          err_set[0] = 1'b1;
        end else begin
          entry_d = {entry_q[27:0], dval};
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == 4'd7) ? ENTRY_FULL : ENTRY_PARTIAL;
        end
      end else if (is_bksp) begin
        if (state_q != ENTRY_EMPTY) begin
          entry_d = entry_q >> 4;
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q == 4'd1) ? ENTRY_EMPTY : ENTRY_PARTIAL;
        end
      end else if (is_enter && state_q != ENTRY_EMPTY) begin
        // A same-cycle pop frees the slot this push needs.
        if (!full || pop_ok) begin
          push    = 1'b1;
          entry_d = '0;
          cnt_d   = 4'd0;
          state_d = ENTRY_EMPTY;
        end else begin
          err_set[1] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY_EMPTY;
      entry_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      err_q   <= (err_q & ~{2{err_clr}}) | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_q;
  end

  assign entry_value = entry_q;
  assign digit_cnt   = cnt_q;
  assign err         = err_q;
  assign fifo_count  = count_q;
  assign fifo_empty  = empty;
  assign fifo_full   = full;
  assign rd_data     = empty ? 32'h0 : mem[rd_ptr];

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: directed plan plus random key/pop traffic,
// checked against a digit-list/queue model and a popped-word scoreboard.
module tb_keypad_entry_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_coord;
  logic        rd_en;
  logic        err_clr;
  logic [31:0] entry_value;
  logic [3:0]  digit_cnt;
  logic [31:0] rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic [1:0]  err;

  keypad_entry_buffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_coord(key_coord), .rd_en(rd_en),
    .err_clr(err_clr), .entry_value(entry_value), .digit_cnt(digit_cnt),
    .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          digs[$];
  logic [31:0] sb[$];
  logic [1:0]  m_err;
  string       keymap = "123A456B789C*0#D";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_value();
    logic [31:0] v = 0;
    foreach (digs[i]) v = v * 16 + 32'(digs[i]);
    return v;
  endfunction

  function automatic int nib_pos(input logic [3:0] n);
    logic [3:0] onehot;
    for (int i = 1; i <= 4; i++) begin
      onehot = 4'b1000 >> (i - 1);
      if (n == ~onehot) return i;
    end
    return 0;
  endfunction

  function automatic logic [7:0] coord_of(input int r, input int c);
    logic [3:0] rh, ch;
    rh = 4'b1000 >> (r - 1);
    ch = 4'b1000 >> (c - 1);
    return {~rh, ~ch};
  endfunction

  task automatic model_update(input logic [7:0] kc, input logic clr, input logic r);
    int rp, cp;
    byte k;
    logic [1:0] set;
    if (r) begin
      digs.delete();
      sb.delete();
      m_err = 0;
      return;
    end
    set = 0;
    rp = nib_pos(kc[7:4]);
    cp = nib_pos(kc[3:0]);
    if (rp != 0 && cp != 0) begin
      k = keymap[(rp - 1) * 4 + (cp - 1)];
      if (k == "*") begin
        if (digs.size() > 0) void'(digs.pop_back());
      end else if (k == "#") begin
        // sb has already lost the head if a pop happened this cycle
        if (digs.size() > 0) begin
          if (sb.size() < DEPTH) begin
            sb.push_back(m_value());
            digs.delete();
          end else set[1] = 1'b1;
        end
      end else begin
        if (digs.size() < 8)
          digs.push_back((k >= "A") ? int'(k - "A") + 10 : int'(k - "0"));
        else set[0] = 1'b1;
      end
    end
    m_err = (clr ? 2'b00 : m_err) | set;
  endtask

  task automatic compare_all();
    chk("entry_value", entry_value, m_value());
    chk("digit_cnt", 32'(digit_cnt), 32'(digs.size()));
    chk("err", 32'(err), 32'(m_err));
    chk("fifo_count", 32'(fifo_count), 32'(sb.size()));
    chk("fifo_empty", 32'(fifo_empty), 32'(sb.size() == 0));
    chk("fifo_full", 32'(fifo_full), 32'(sb.size() == DEPTH));
    chk("rd_data", rd_data, (sb.size() == 0) ? 32'h0 : sb[0]);
  endtask

  task automatic step(input logic [7:0] kc, input logic rd, input logic clr, input logic r);
    key_coord = kc;
    rd_en     = rd;
    err_clr   = clr;
    rst       = r;
    @(posedge clk);
    #1;
    model_update(kc, clr, r);
    compare_all();
  endtask

  // Scoreboard monitor: every pop the CPU issues must see the expected head word.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (!rst && rd_en && sb.size() > 0) begin
      exp_w = sb.pop_front();
      chk("pop_data", rd_data, exp_w);
      chk("pop_not_empty", 32'(fifo_empty), 32'h0);
    end
  end

  initial begin
    key_coord = 0; rd_en = 0; err_clr = 0; rst = 1;
    m_err = 0;
    @(posedge clk);
    #1;
    compare_all();

    step(8'h00, 0, 0, 0);
    step(8'h77, 0, 0, 0); step(8'h7B, 0, 0, 0); step(8'h7E, 0, 0, 0);
    chk("plan1_entry", entry_value, 32'h0000_012A);
    chk("plan1_cnt", 32'(digit_cnt), 32'd3);

    step(8'h00, 0, 0, 1);
    step(8'h77, 0, 0, 0); step(8'h7B, 0, 0, 0); step(8'h7D, 0, 0, 0);
    step(8'hE7, 0, 0, 0); step(8'hB7, 0, 0, 0); step(8'hED, 0, 0, 0);
    chk("plan2_rd_data", rd_data, 32'h0000_0124);
    chk("plan2_entry", entry_value, 32'h0);
    chk("plan2_count", 32'(fifo_count), 32'd1);
    step(8'h00, 1, 0, 0);

    for (int i = 0; i < 9; i++) step(8'hDD, 0, 0, 0);
    chk("plan3_entry", entry_value, 32'h9999_9999);
    chk("plan3_cnt", 32'(digit_cnt), 32'd8);
    chk("plan3_err", 32'(err), 32'd1);
    step(8'h00, 0, 1, 0);
    chk("plan3_clr", 32'(err), 32'd0);

    step(8'h00, 0, 0, 1);
    for (int r = 1; r <= 4; r++) begin
      step(coord_of(r <= 3 ? 1 : 2, r <= 3 ? r : 1), 0, 0, 0);
      step(8'hED, 0, 0, 0);
    end
    chk("plan4_full", 32'(fifo_full), 32'd1);
    step(8'hBB, 0, 0, 0); step(8'hED, 0, 0, 0);
    chk("plan4_err", 32'(err), 32'd2);
    chk("plan4_retain", entry_value, 32'h5);
    step(8'hED, 1, 0, 0);
    chk("plan4_head", rd_data, 32'h2);
    chk("plan4_count", 32'(fifo_count), 32'd4);
    chk("plan4_cleared", entry_value, 32'h0);
    step(8'h00, 1, 0, 0); step(8'h00, 1, 0, 0); step(8'h00, 1, 0, 0);
    chk("plan4_tail", rd_data, 32'h5);

    step(8'h00, 0, 0, 1);
    step(8'h33, 0, 0, 0); step(8'hE7, 0, 0, 0); step(8'hED, 0, 0, 0); step(8'h00, 1, 0, 0);
    chk("plan5_err", 32'(err), 32'd0);
    chk("plan5_empty", 32'(fifo_empty), 32'd1);

    step(8'h77, 0, 0, 0); step(8'hED, 0, 0, 0); step(8'h7B, 0, 0, 0); step(8'hED, 0, 0, 0);
    step(8'h77, 0, 0, 0); step(8'h7B, 0, 0, 0); step(8'h7D, 0, 0, 0);
    step(8'h00, 0, 0, 1);
    chk("plan6_entry", entry_value, 32'h0);
    chk("plan6_count", 32'(fifo_count), 32'd0);
    chk("plan6_rd_data", rd_data, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] kc;
      logic rd, clr, r;
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 12)       kc = coord_of($urandom_range(1, 4), $urandom_range(1, 4));
      else if (sel < 15)  kc = 8'hED;
      else if (sel < 16)  kc = 8'hE7;
      else if (sel < 18)  kc = 8'h00;
      else                kc = 8'($urandom);
      rd  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 299) == 0);
      if (r) rd = 1'b0;
      step(kc, rd, clr, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
